// File: rtl/cosim_commit_pkg.sv
// ----------------------------------------------------------------------------
// cosim_commit_pkg
// Shared types for the co-simulation commit collector.
//   commit_rec_t : one retirement record; field order matches the DPI commit
//                  record consumed by the checker, so do not reorder fields.
//   fifo_entry_t : a buffered record together with its sequence number.
// No ports (package).
// ----------------------------------------------------------------------------
package cosim_commit_pkg;

    localparam int PC_W    = 64;
    localparam int INS_W   = 32;
    localparam int RD_W    = 5;
    localparam int WDATA_W = 64;
    localparam int CAUSE_W = 64;
    localparam int PRIV_W  = 2;
    localparam int SEQ_W   = 64;
    localparam int HART_W  = 16;
    localparam int DROP_W  = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INS_W-1:0]   ins;
        logic [RD_W-1:0]    rd;
        logic               rd_we;
        logic [WDATA_W-1:0] wdata;
        logic               xcpt;
        logic [CAUSE_W-1:0] xcpt_cause;
        logic [PRIV_W-1:0]  priv;
    } commit_rec_t;

    typedef struct packed {
        commit_rec_t       rec;
        logic [SEQ_W-1:0]  seq;
    } fifo_entry_t;

endpackage

// File: rtl/cosim_commit_collector_if.sv
// ----------------------------------------------------------------------------
// cosim_commit_collector_if
// Bundles the retirement-side and checker-side handshake of the collector.
// Signal suffixes are relative to the collector (_i = into it, _o = out of it).
//   cmt_valid_i  per-port retire valid, port 0 older
//   cmt_rec_i    per-port commit record
//   stall_o      hold-retirement request to the core
//   rec_valid_o  head record valid
//   rec_ready_i  checker consumes head
//   rec_o        head record
//   rec_seq_o    head sequence number
//   rec_hart_o   hart index
// Modports: slave = collector, master = core/checker side (or a testbench).
// ----------------------------------------------------------------------------
interface cosim_commit_collector_if
    import cosim_commit_pkg::*;
#(
    parameter int COMMIT_PORTS = 2
) ();

    logic [COMMIT_PORTS-1:0]        cmt_valid_i;
    commit_rec_t [COMMIT_PORTS-1:0] cmt_rec_i;
    logic                           stall_o;
    logic                           rec_valid_o;
    logic                           rec_ready_i;
    commit_rec_t                    rec_o;
    logic [SEQ_W-1:0]               rec_seq_o;
    logic [HART_W-1:0]              rec_hart_o;

    modport master (
        output cmt_valid_i, cmt_rec_i, rec_ready_i,
        input  stall_o, rec_valid_o, rec_o, rec_seq_o, rec_hart_o
    );

    modport slave (
        input  cmt_valid_i, cmt_rec_i, rec_ready_i,
        output stall_o, rec_valid_o, rec_o, rec_seq_o, rec_hart_o
    );

endinterface

// File: rtl/cosim_commit_fifo.sv
// ----------------------------------------------------------------------------
// cosim_commit_fifo
// Dual-push, single-pop registered FIFO (not fall-through).
//   clk_i, rst_i  clock, synchronous active-high reset (pointers only)
//   i_push0       write i_data0 at the tail
//   i_push1       write i_data1 behind i_data0; only asserted with i_push0
//   i_pop         drop the head; only asserted while o_valid
//   o_head        head entry
//   o_valid       FIFO non-empty
//   o_count       occupied entries, 0..DEPTH
// Pointers carry one extra MSB so full and empty are distinguishable;
// the storage array itself is never reset.
// ----------------------------------------------------------------------------
module cosim_commit_fifo
    import cosim_commit_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_push0,
    input  logic        i_push1,
    input  fifo_entry_t i_data0,
    input  fifo_entry_t i_data1,
    input  logic        i_pop,
    output fifo_entry_t o_head,
    output logic        o_valid,
    output logic [CW-1:0] o_count
);

    fifo_entry_t   r_mem [DEPTH];
    logic [CW-1:0] r_wrPtr;
    logic [CW-1:0] r_rdPtr;
    logic [CW-1:0] w_wrPtrNext1;

    assign w_wrPtrNext1 = r_wrPtr + CW'(1);

    // Storage writes; the second record lands in the slot right after the first.
    always_ff @(posedge clk_i) begin
        if (i_push0) r_mem[r_wrPtr[AW-1:0]]      <= i_data0;
        if (i_push1) r_mem[w_wrPtrNext1[AW-1:0]] <= i_data1;
    end

    // Pointer update; reset empties the FIFO and discards buffered records.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            r_wrPtr <= r_wrPtr + CW'(i_push0) + CW'(i_push1);
            if (i_pop) r_rdPtr <= r_rdPtr + CW'(1);
        end
    end

    assign o_count = r_wrPtr - r_rdPtr;
    assign o_valid = (o_count != '0);
    assign o_head  = r_mem[r_rdPtr[AW-1:0]];

endmodule

// File: rtl/cosim_commit_collector.sv
// ----------------------------------------------------------------------------
// cosim_commit_collector
// Per-hart retirement collector for co-simulation commit checking. Buffers up
// to COMMIT_PORTS retirements per cycle in order, tags each with a 64-bit
// sequence number and presents them one at a time to the checker.
//   clk_i, rst_i  clock, synchronous active-high reset
//   bus           cosim_commit_collector_if.slave (retire + checker handshake)
//   count_o       occupied entries, 0..DEPTH
//   overflow_o    sticky: a record was dropped
//   drop_cnt_o    dropped records, saturating
//   proto_err_o   sticky: port 1 valid without port 0 valid
//   hang_o        sticky watchdog flag
// Optional feature: define COSIM_CMT_WATCHDOG_EN to enable the hang watchdog;
// without it hang_o is tied low.
// ----------------------------------------------------------------------------
module cosim_commit_collector
    import cosim_commit_pkg::*;
#(
    parameter  int HART_ID      = 0,
    parameter  int DEPTH        = 16,
    parameter  int COMMIT_PORTS = 2,
    parameter  int WDOG_CYCLES  = 4096,
    localparam int CW           = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cosim_commit_collector_if.slave bus,
    output logic [CW-1:0]         count_o,
    output logic                  overflow_o,
    output logic [DROP_W-1:0]     drop_cnt_o,
    output logic                  proto_err_o,
    output logic                  hang_o
);

    logic              w_v0;
    logic              w_v1;
    commit_rec_t       w_rec1;
    logic              w_slotAReq;
    logic              w_slotBReq;
    logic              w_pushA;
    logic              w_pushB;
    logic              w_pop;
    logic              w_fifoValid;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_room;
    logic [CW-1:0]     w_countNext;
    logic [1:0]        w_nDrop;
    logic [DROP_W:0]   w_dropSum;
    fifo_entry_t       w_entryA;
    fifo_entry_t       w_entryB;
    fifo_entry_t       w_head;

    logic [SEQ_W-1:0]  r_nextSeq;
    logic              r_stall;
    logic              r_overflow;
    logic [DROP_W-1:0] r_dropCnt;
    logic              r_protoErr;

    assign w_v0 = bus.cmt_valid_i[0];

    generate
        if (COMMIT_PORTS == 2) begin : g_twoPorts
            assign w_v1   = bus.cmt_valid_i[1];
            assign w_rec1 = bus.cmt_rec_i[1];
        end else begin : g_onePort
            assign w_v1   = 1'b0;
            assign w_rec1 = '0;
        end
    endgenerate

    // Valid records are packed oldest-first into slots A/B, so a lone port-1
    // record (protocol error case) still enters through slot A.
    assign w_slotAReq = w_v0 | w_v1;
    assign w_slotBReq = w_v0 & w_v1;

    // Room = free entries at cycle start plus the slot a same-cycle pop frees.
    assign w_pop   = w_fifoValid & bus.rec_ready_i;
    assign w_room  = (CW'(DEPTH) - w_count) + CW'(w_pop);
    assign w_pushA = w_slotAReq & (w_room >= CW'(1));
    assign w_pushB = w_slotBReq & (w_room >= CW'(2));
    assign w_nDrop = 2'(w_slotAReq & ~w_pushA) + 2'(w_slotBReq & ~w_pushB);

    // Dropped records consume no sequence number because slot B only exists
    // when slot A is pushed.
    assign w_entryA = {(w_v0 ? bus.cmt_rec_i[0] : w_rec1), r_nextSeq};
    assign w_entryB = {w_rec1, r_nextSeq + SEQ_W'(1)};

    assign w_countNext = w_count + CW'(w_pushA) + CW'(w_pushB) - CW'(w_pop);
    assign w_dropSum   = {1'b0, r_dropCnt} + (DROP_W+1)'(w_nDrop);

    cosim_commit_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push0 (w_pushA),
        .i_push1 (w_pushB),
        .i_data0 (w_entryA),
        .i_data1 (w_entryB),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_fifoValid),
        .o_count (w_count)
    );

    // Sequence counter, registered stall and sticky error bookkeeping.
    // stall_o looks at the occupancy after this cycle's push/pop so the core,
    // reacting one cycle later, still finds enough room.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_nextSeq  <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
            r_dropCnt  <= '0;
            r_protoErr <= 1'b0;
        end else begin
            r_nextSeq <= r_nextSeq + SEQ_W'(w_pushA) + SEQ_W'(w_pushB);
            r_stall   <= (CW'(DEPTH) - w_countNext) < CW'(COMMIT_PORTS);
            if (w_nDrop != 2'd0) begin
                r_overflow <= 1'b1;
                r_dropCnt  <= w_dropSum[DROP_W] ? '1 : w_dropSum[DROP_W-1:0];
            end
            if (w_v1 && !w_v0) r_protoErr <= 1'b1;
        end
    end

`ifdef COSIM_CMT_WATCHDOG_EN
    logic [31:0] r_wdogCnt;
    logic        r_hang;

    // Cycles since the last accepted record; only an empty FIFO counts as a
    // hang, a full FIFO waiting on the checker does not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wdogCnt <= '0;
            r_hang    <= 1'b0;
        end else begin
            if (w_pushA)               r_wdogCnt <= '0;
            else if (r_wdogCnt != '1)  r_wdogCnt <= r_wdogCnt + 32'd1;
            if ((r_wdogCnt >= 32'(WDOG_CYCLES)) && !w_fifoValid) r_hang <= 1'b1;
        end
    end

    assign hang_o = r_hang;
`else
    assign hang_o = 1'b0;
`endif

    // Head fields are masked while empty so the never-reset storage is not visible.
    assign bus.rec_valid_o = w_fifoValid;
    assign bus.rec_o       = w_fifoValid ? w_head.rec : '0;
    assign bus.rec_seq_o   = w_fifoValid ? w_head.seq : '0;
    assign bus.rec_hart_o  = HART_W'(HART_ID);
    assign bus.stall_o     = r_stall;

    assign count_o     = w_count;
    assign overflow_o  = r_overflow;
    assign drop_cnt_o  = r_dropCnt;
    assign proto_err_o = r_protoErr;

endmodule

// File: tb/tb_cosim_commit_collector.sv
// ----------------------------------------------------------------------------
// tb_cosim_commit_collector
// Self-checking bench for cosim_commit_collector (DEPTH=16, 2 ports,
// WDOG_CYCLES=64, HART_ID=5). Expected records are queued when driven and
// compared when the collector hands them to the checker. Watchdog checks
// follow COSIM_CMT_WATCHDOG_EN.
// ----------------------------------------------------------------------------
module tb_cosim_commit_collector;
    import cosim_commit_pkg::*;

    localparam int DEPTH = 16;
    localparam int CP    = 2;
    localparam int WDOG  = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        commit_rec_t      rec;
        logic [63:0]      seq;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   dropCnt;
    logic          protoErr;
    logic          hang;

    exp_t          sb[$];
    logic [63:0]   mSeq;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    cosim_commit_collector_if #(.COMMIT_PORTS(CP)) cif ();

    cosim_commit_collector #(
        .HART_ID      (5),
        .DEPTH        (DEPTH),
        .COMMIT_PORTS (CP),
        .WDOG_CYCLES  (WDOG)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (cif.slave),
        .count_o     (count),
        .overflow_o  (overflow),
        .drop_cnt_o  (dropCnt),
        .proto_err_o (protoErr),
        .hang_o      (hang)
    );

    // Checker side: every record handed over must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && cif.rec_valid_o === 1'b1 && cif.rec_ready_i === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL pop_unexpected: got seq %0d, required no record", cif.rec_seq_o);
            end else begin
                e = sb.pop_front();
                if (cif.rec_o !== e.rec || cif.rec_seq_o !== e.seq) begin
                    errors++;
                    $display("[TB] FAIL pop_record: got pc=%h seq=%0d, required pc=%h seq=%0d",
                             cif.rec_o.pc, cif.rec_seq_o, e.rec.pc, e.seq);
                end
            end
        end
    end

    function automatic commit_rec_t mkRec(input logic [63:0] pc);
        commit_rec_t r;
        r.pc         = pc;
        r.ins        = $urandom;
        r.rd         = 5'($urandom);
        r.rd_we      = 1'($urandom);
        r.wdata      = {$urandom, $urandom};
        r.xcpt       = 1'($urandom);
        r.xcpt_cause = {$urandom, $urandom};
        r.priv       = 2'($urandom);
        return r;
    endfunction

    function automatic void sbPush(input commit_rec_t r);
        exp_t e;
        e.rec = r;
        e.seq = mSeq;
        sb.push_back(e);
        mSeq++;
    endfunction

    // One clock cycle: drive, model acceptance after the checker pop, advance.
    task automatic step(input logic [1:0] v, input logic [63:0] pcA, input logic [63:0] pcB,
                        input logic rdy);
        commit_rec_t r0, r1;
        int room;
        r0 = mkRec(pcA);
        r1 = mkRec(pcB);
        cif.cmt_valid_i  = v;
        cif.cmt_rec_i[0] = r0;
        cif.cmt_rec_i[1] = r1;
        cif.rec_ready_i  = rdy;
        @(negedge clk);
        #1;
        room = DEPTH - sb.size();
        if (v == 2'b11) begin
            if (room >= 1) sbPush(r0);
            if (room >= 2) sbPush(r1);
        end else if (v == 2'b01) begin
            if (room >= 1) sbPush(r0);
        end else if (v == 2'b10) begin
            if (room >= 1) sbPush(r1);
        end
        @(posedge clk);
        #1;
        cif.cmt_valid_i = 2'b00;
    endtask

    task automatic doReset();
        rst             = 1'b1;
        cif.cmt_valid_i = 2'b00;
        cif.cmt_rec_i   = '0;
        cif.rec_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        mSeq = '0;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if ({cif.rec_valid_o, cif.stall_o, overflow, protoErr, hang} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got valid/stall/ovf/proto/hang=%b, required 00000",
                     {cif.rec_valid_o, cif.stall_o, overflow, protoErr, hang});
        end
        checks++;
        if (count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d, required 0", count);
        end
        checks++;
        if (dropCnt !== 32'd0 || cif.rec_seq_o !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_cnts: got drop=%0d seq=%0d, required 0/0", dropCnt, cif.rec_seq_o);
        end
    endtask

    task automatic test_single_push();
        doReset();
        repeat (3) step(2'b00, 64'd0, 64'd0, 1'b1);
        step(2'b01, 64'h8000_0000, 64'd0, 1'b1);
        checks++;
        if (cif.rec_valid_o !== 1'b1 || count !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL single_visible: got valid=%b count=%0d, required 1/1", cif.rec_valid_o, count);
        end
        checks++;
        if (cif.rec_seq_o !== 64'd0 || cif.rec_o.pc !== 64'h8000_0000 || cif.rec_hart_o !== 16'd5) begin
            errors++;
            $display("[TB] FAIL single_head: got seq=%0d pc=%h hart=%0d, required 0/80000000/5",
                     cif.rec_seq_o, cif.rec_o.pc, cif.rec_hart_o);
        end
        step(2'b00, 64'd0, 64'd0, 1'b1);
        checks++;
        if (count !== '0 || cif.rec_valid_o !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL single_drain: got count=%0d valid=%b pending=%0d, required 0/0/0",
                     count, cif.rec_valid_o, sb.size());
        end
    endtask

    task automatic test_dual_push();
        doReset();
        step(2'b11, 64'hA000, 64'hB000, 1'b0);
        checks++;
        if (count !== CW'(2)) begin
            errors++;
            $display("[TB] FAIL dual_peak: got count=%0d, required 2", count);
        end
        step(2'b00, 64'd0, 64'd0, 1'b1);
        checks++;
        if (count !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL dual_after_pop: got count=%0d, required 1", count);
        end
        step(2'b00, 64'd0, 64'd0, 1'b1);
        checks++;
        if (count !== '0 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL dual_drain: got count=%0d pending=%0d, required 0/0", count, sb.size());
        end
    endtask

    task automatic test_stall();
        logic [1:0] v;
        doReset();
        for (int i = 0; i < 12; i++) begin
            v = (cif.stall_o === 1'b1) ? 2'b00 : 2'b11;
            step(v, 64'(32'h100 + i * 8), 64'(32'h104 + i * 8), 1'b0);
            checks++;
            if (count !== CW'(sb.size()) || cif.stall_o !== (sb.size() >= DEPTH - CP + 1)) begin
                errors++;
                $display("[TB] FAIL stall_cycle%0d: got count=%0d stall=%b, required %0d/%b",
                         i, count, cif.stall_o, sb.size(), (sb.size() >= DEPTH - CP + 1));
            end
        end
        checks++;
        if (dropCnt !== 32'd0 || overflow !== 1'b0 || count !== CW'(DEPTH)) begin
            errors++;
            $display("[TB] FAIL stall_nodrop: got drop=%0d ovf=%b count=%0d, required 0/0/16",
                     dropCnt, overflow, count);
        end
    endtask

    task automatic test_overflow();
        int n;
        doReset();
        for (int i = 0; i < 9; i++) step(2'b11, 64'(32'h2000 + i * 8), 64'(32'h2004 + i * 8), 1'b0);
        checks++;
        if (count !== CW'(16) || dropCnt !== 32'd2 || overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_fill: got count=%0d drop=%0d ovf=%b, required 16/2/1",
                     count, dropCnt, overflow);
        end
        step(2'b01, 64'h3000, 64'd0, 1'b1);
        checks++;
        if (count !== CW'(16) || dropCnt !== 32'd2) begin
            errors++;
            $display("[TB] FAIL ovf_push_pop_full: got count=%0d drop=%0d, required 16/2", count, dropCnt);
        end
        n = 0;
        while (sb.size() != 0 && n < 24) begin
            step(2'b00, 64'd0, 64'd0, 1'b1);
            n++;
        end
        checks++;
        if (count !== '0 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL ovf_drain: got count=%0d pending=%0d, required 0/0", count, sb.size());
        end
    endtask

    task automatic test_proto_err();
        doReset();
        step(2'b10, 64'd0, 64'h4444, 1'b0);
        checks++;
        if (protoErr !== 1'b1 || count !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL proto_set: got proto=%b count=%0d, required 1/1", protoErr, count);
        end
        repeat (3) step(2'b00, 64'd0, 64'd0, 1'b0);
        step(2'b00, 64'd0, 64'd0, 1'b1);
        checks++;
        if (protoErr !== 1'b1 || count !== '0) begin
            errors++;
            $display("[TB] FAIL proto_sticky: got proto=%b count=%0d, required 1/0", protoErr, count);
        end
        step(2'b11, 64'h5000, 64'h5004, 1'b0);
        step(2'b11, 64'h5008, 64'h500C, 1'b0);
        doReset();
        checks++;
        if (count !== '0 || cif.rec_valid_o !== 1'b0 || protoErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_midop: got count=%0d valid=%b proto=%b, required 0/0/0",
                     count, cif.rec_valid_o, protoErr);
        end
    endtask

    task automatic test_watchdog();
        doReset();
        repeat (60) step(2'b00, 64'd0, 64'd0, 1'b0);
        checks++;
        if (hang !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wdog_early: got hang=%b, required 0", hang);
        end
`ifdef COSIM_CMT_WATCHDOG_EN
        for (int i = 0; i < 40; i++) begin
            if (hang === 1'b1) break;
            step(2'b00, 64'd0, 64'd0, 1'b0);
        end
        checks++;
        if (hang !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wdog_fire: got hang=%b, required 1", hang);
        end
`else
        repeat (40) step(2'b00, 64'd0, 64'd0, 1'b0);
        checks++;
        if (hang !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wdog_off: got hang=%b, required 0", hang);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_dual_push();
        test_stall();
        test_overflow();
        test_proto_err();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no completion, required completion before 100000");
        $fatal(1, "[TB] time limit exceeded");
    end

endmodule
